// File: rtl/btn_addr_stepper_pkg.sv
// Shared board constants and step encoding for the button-driven LED address stepper.
// Parameter defaults give a 10 ms debounce and a 4 Hz auto step at CLK_HZ.
package btn_addr_stepper_pkg;

    localparam int LED_ADDR_W   = 3;
    localparam int LED_ADDR_MAX = 6;
    localparam int CLK_HZ       = 12_000_000;

    localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;
    localparam int AUTO_DIV_DEFAULT        = CLK_HZ / 4;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN
    } step_e;

endpackage

// File: rtl/btn_addr_stepper_debounce.sv
// One button channel: 2-FF synchroniser, stable-level debouncer and a
// single-cycle press pulse raised on the same edge a 0->1 change is accepted.
module btn_debounce
    import btn_addr_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             accept;

    // The counter only runs while the synchronised level disagrees with the
    // accepted one, so any bounce back to the old level restarts the wait.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        count_d  = '0;
        accept   = 1'b0;
        if (sync2_q != stable_q) begin
            if (count_q == CNT_LAST) begin
                accept   = 1'b1;
                stable_d = sync2_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    assign press = accept & sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/btn_addr_stepper.sv
// Turns raw BTN1..BTN3 pins into a wrap-around LED address: up/down steps,
// plus an auto mode that free-runs the address from a prescaler tick.
module btn_addr_stepper
    import btn_addr_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int AUTO_DIV        = AUTO_DIV_DEFAULT,
    parameter int ADDR_W          = LED_ADDR_W,
    parameter int ADDR_MAX        = LED_ADDR_MAX
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BTN1,
    input  logic              BTN2,
    input  logic              BTN3,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_changed,
    output logic              auto_mode
);

    localparam int PRE_W = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(AUTO_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_MAX);

    logic              press_up, press_down, press_auto;
    logic              tick;
    step_e             step;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              changed_q, changed_d;
    logic              auto_q, auto_d;
    logic [PRE_W-1:0]  presc_q, presc_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
        .clk(CLK), .rst(RST), .btn_raw(BTN1), .press(press_up)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
        .clk(CLK), .rst(RST), .btn_raw(BTN2), .press(press_down)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_auto (
        .clk(CLK), .rst(RST), .btn_raw(BTN3), .press(press_auto)
    );

    // Conflicting manual presses cancel each other and also swallow the tick;
    // a lone manual press always wins over the tick.
    always_comb begin
        tick      = auto_q && (presc_q == PRE_LAST);
        step      = STEP_NONE;
        addr_d    = addr_q;
        changed_d = 1'b0;
        auto_d    = auto_q;
        presc_d   = presc_q;

        if (press_up ^ press_down) begin
            step = press_up ? STEP_UP : STEP_DOWN;
        end else if (!press_up && tick) begin
            step = STEP_UP;
        end

        if (press_auto) begin
            auto_d  = !auto_q;
            presc_d = '0;
        end else if (!auto_q || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        case (step)
            STEP_UP: begin
                addr_d    = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                changed_d = 1'b1;
            end
            STEP_DOWN: begin
                addr_d    = (addr_q == '0) ? ADDR_LAST : addr_q - 1'b1;
                changed_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q    <= '0;
            changed_q <= 1'b0;
            auto_q    <= 1'b0;
            presc_q   <= '0;
        end else begin
            addr_q    <= addr_d;
            changed_q <= changed_d;
            auto_q    <= auto_d;
            presc_q   <= presc_d;
        end
    end

    assign addr         = addr_q;
    assign addr_changed = changed_q;
    assign auto_mode    = auto_q;

endmodule
